// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared constants, channel state encoding and time conversion for key_conditioner
package key_cond_pkg;
  localparam int CLK_HZ = 50_000_000;
  typedef enum logic [1:0] {REL, HOLD, RPT} chan_state_e;
  function automatic int ms_to_cycles(input int ms);
    return CLK_HZ / 1000 * ms;
  endfunction
endpackage

// File: rtl/key_channel.sv
// key_channel: synchronise, debounce and generate press/release/repeat pulses for one key
module key_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] RD_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RP_LAST = HW'(REPEAT_PERIOD - 1);
  logic [1:0] sync_q;
  logic s, accept;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d, repeat_q, repeat_d;
  chan_state_e state_q, state_d;
  assign s = ~sync_q[1];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= 2'b11;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      state_q   <= REL;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n_i};
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end
  always_comb begin
    accept    = (s != level_q) && (dcnt_q == D_LAST);
    dcnt_d    = (s == level_q || accept) ? '0 : dcnt_q + 1'b1;
    level_d   = accept ? s : level_q;
    press_d   = accept && s;
    release_d = accept && !s;
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    repeat_d  = 1'b0;
    // a release always wins over a repeat that falls due on the same edge
    if (release_d) begin
      state_d = REL;
      hcnt_d  = '0;
    end else if (state_q == REL) begin
      if (press_d) begin
        state_d = HOLD;
        hcnt_d  = '0;
      end
    end else if (state_q == HOLD) begin
      if (hcnt_q != RD_LAST) hcnt_d = hcnt_q + 1'b1;
      else if (REPEAT_EN) begin
        repeat_d = 1'b1;
        state_d  = RPT;
        hcnt_d   = '0;
      end
    end else begin
      repeat_d = hcnt_q == RP_LAST;
      hcnt_d   = repeat_d ? '0 : hcnt_q + 1'b1;
    end
  end
  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: turns raw active-low KEY buttons into debounced levels and single-cycle event strobes
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int               N_KEYS          = 4,
  parameter int               DEBOUNCE_CYCLES = ms_to_cycles(20),
  parameter int               REPEAT_DELAY    = ms_to_cycles(500),
  parameter int               REPEAT_PERIOD   = ms_to_cycles(100),
  parameter logic [N_KEYS-1:0] REPEAT_EN      = N_KEYS'(4'b0110)
) (
  input  logic              CLOCK_50_i,
  input  logic              RESET_i,
  input  logic [N_KEYS-1:0] KEY_i,
  output logic [N_KEYS-1:0] level_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic [N_KEYS-1:0] repeat_o,
  output logic [N_KEYS-1:0] strobe_o
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_EN[i])
    ) u_ch (
      .clk_i    (CLOCK_50_i),
      .rst_i    (RESET_i),
      .key_n_i  (KEY_i[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .repeat_o (repeat_o[i])
    );
  end
  assign strobe_o = press_o | repeat_o;
endmodule
